ysyx_22040750_ifu: RTL

//  PC register + instruction-fetch unit; consumer end of the dnpc valid/ready handshake driven by the next-PC generator.

---
 rtl/ysyx_22040750_ifu_pkg.sv | 16 +
 rtl/ysyx_22040750_ifu_if.sv | 32 +++
 rtl/ysyx_22040750_ifu_ctrl.sv | 71 +++++++
 rtl/ysyx_22040750_ifu.sv | 55 +++++
 4 files changed

// File: rtl/ysyx_22040750_ifu_pkg.sv
// ysyx_22040750_ifu_pkg: shared widths, reset defaults and FSM state encodings for the IFU.
package ysyx_22040750_ifu_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [ILEN-1:0] NOP_INST_DEF = 32'h0000_0013;
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NPC  = 2'd3
    } state_e;
    function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction
endpackage

// File: rtl/ysyx_22040750_ifu_if.sv
// ysyx_22040750_ifu_if: dnpc, imem and IF/ID handshake bundle; slave is the IFU side, master the environment.
interface ysyx_22040750_ifu_if;
    import ysyx_22040750_ifu_pkg::*;
    logic [XLEN-1:0] I_dnpc;
    logic            I_pc_valid;
    logic            O_pc_ready;
    logic            O_imem_req_valid;
    logic            I_imem_req_ready;
    logic [XLEN-1:0] O_imem_addr;
    logic            I_imem_resp_valid;
    logic [ILEN-1:0] I_imem_rdata;
    logic            O_IF_ID_valid;
    logic            I_IF_ID_ready;
    logic [XLEN-1:0] O_pc;
    logic [XLEN-1:0] O_snpc;
    logic [ILEN-1:0] O_inst;
    logic            I_flush;
    logic [XLEN-1:0] I_flush_pc;
    logic [63:0]     O_fetch_cnt;
    modport slave (
        input  I_dnpc, I_pc_valid, I_imem_req_ready, I_imem_resp_valid, I_imem_rdata,
               I_IF_ID_ready, I_flush, I_flush_pc,
        output O_pc_ready, O_imem_req_valid, O_imem_addr, O_IF_ID_valid, O_pc, O_snpc,
               O_inst, O_fetch_cnt
    );
    modport master (
        output I_dnpc, I_pc_valid, I_imem_req_ready, I_imem_resp_valid, I_imem_rdata,
               I_IF_ID_ready, I_flush, I_flush_pc,
        input  O_pc_ready, O_imem_req_valid, O_imem_addr, O_IF_ID_valid, O_pc, O_snpc,
               O_inst, O_fetch_cnt
    );
endinterface

// File: rtl/ysyx_22040750_ifu_ctrl.sv
// ysyx_22040750_ifu_ctrl: fetch FSM plus the drop flag that swallows the response of a killed fetch.
module ysyx_22040750_ifu_ctrl
    import ysyx_22040750_ifu_pkg::*;
(
    input  logic I_clk,
    input  logic I_rst,
    input  logic req_ready,
    input  logic resp_valid,
    input  logic if_id_ready,
    input  logic pc_valid,
    input  logic flush,
    output logic req_valid,
    output logic if_id_valid,
    output logic pc_ready,
    output logic load_inst,
    output logic load_npc
);
    state_e state_q, state_d;
    logic   drop_q, drop_d;
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        req_valid   = 1'b0;
        if_id_valid = 1'b0;
        pc_ready    = 1'b0;
        load_inst   = 1'b0;
        load_npc    = 1'b0;
        if (!I_rst) begin
            unique case (state_q)
                S_REQ: begin
                    req_valid = 1'b1;
                    // a request accepted in the flush cycle was for the old pc, so its data must be dropped
                    if (req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = flush;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        load_inst = !(flush || drop_q);
                        state_d   = (flush || drop_q) ? S_REQ : S_OUT;
                        drop_d    = 1'b0;
                    end else if (flush) begin
                        drop_d = 1'b1;
                    end
                end
                S_OUT: begin
                    if_id_valid = !flush;
                    state_d     = flush ? S_REQ : (if_id_ready ? S_NPC : S_OUT);
                end
                S_NPC: begin
                    pc_ready = !flush;
                    load_npc = !flush && pc_valid;
                    state_d  = (flush || pc_valid) ? S_REQ : S_NPC;
                end
            endcase
        end
    end
    always_ff @(posedge I_clk) begin
        if (!I_rst && state_q != S_WAIT) assert (!resp_valid);
    end
endmodule

// File: rtl/ysyx_22040750_ifu.sv
// ysyx_22040750_ifu: PC register and instruction fetch with IF/ID handshake and flush redirect.
// Define IFU_PERF_CNT_EN to build the 64-bit completed-fetch counter; otherwise O_fetch_cnt is zero.
module ysyx_22040750_ifu
    import ysyx_22040750_ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [ILEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input logic               I_clk,
    input logic               I_rst,
    ysyx_22040750_ifu_if.slave bus
);
    logic [XLEN-1:0] pc_q, pc_d;
    logic [ILEN-1:0] inst_q, inst_d;
    logic            load_inst, load_npc;
    ysyx_22040750_ifu_ctrl u_ctrl (
        .I_clk       (I_clk),
        .I_rst       (I_rst),
        .req_ready   (bus.I_imem_req_ready),
        .resp_valid  (bus.I_imem_resp_valid),
        .if_id_ready (bus.I_IF_ID_ready),
        .pc_valid    (bus.I_pc_valid),
        .flush       (bus.I_flush),
        .req_valid   (bus.O_imem_req_valid),
        .if_id_valid (bus.O_IF_ID_valid),
        .pc_ready    (bus.O_pc_ready),
        .load_inst   (load_inst),
        .load_npc    (load_npc)
    );
    always_comb begin
        pc_d   = bus.I_flush ? bus.I_flush_pc : (load_npc ? bus.I_dnpc : pc_q);
        inst_d = bus.I_flush ? NOP_INST : (load_inst ? bus.I_imem_rdata : inst_q);
    end
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pc_q   <= RESET_PC;
            inst_q <= NOP_INST;
        end else begin
            pc_q   <= pc_d;
            inst_q <= inst_d;
        end
    end
    assign bus.O_imem_addr = pc_q;
    assign bus.O_pc        = pc_q;
    assign bus.O_snpc      = next_seq_pc(pc_q);
    assign bus.O_inst      = inst_q;
`ifdef IFU_PERF_CNT_EN
    logic [63:0] cnt_q, cnt_d;
    always_comb cnt_d = (bus.O_IF_ID_valid && bus.I_IF_ID_ready) ? cnt_q + 64'd1 : cnt_q;
    always_ff @(posedge I_clk) cnt_q <= I_rst ? 64'd0 : cnt_d;
    assign bus.O_fetch_cnt = cnt_q;
`else
    assign bus.O_fetch_cnt = 64'd0;
`endif
endmodule
